// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs selected byte nibbles MSB-first into PACK_N-nibble words
// A flush emits a partial word that is left-aligned and zero-padded on the right.
module nibble_packer #(
   parameter int PACK_N = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [7:0]                       in_data,
   input  logic                             nib_sel,
   input  logic                             flush,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [4*PACK_N-1:0]              out_data,
   output logic [$clog2(PACK_N+1)-1:0]      out_count,
   output logic                             busy
);
   localparam int W  = 4 * PACK_N;
   localparam int CW = $clog2(PACK_N + 1);

   typedef enum logic {FILL, FLUSH_WAIT} state_t;

   state_t          state;
   logic [W-1:0]    acc;
   logic [CW-1:0]   cnt;
   logic            flush_pend;
   logic            slot_free;
   logic            last_slot;
   logic            in_fire;
   logic [3:0]      nib;
   logic [W-1:0]    acc_ins;
   logic [CW-1:0]   held;

   assign flush_pend = (state == FLUSH_WAIT);
   assign slot_free  = !out_valid | out_ready;
   assign last_slot  = (cnt == CW'(PACK_N - 1));
   assign in_ready   = !flush_pend & !(last_slot & !slot_free);
   assign in_fire    = in_valid & in_ready;
   assign nib        = nib_sel ? in_data[7:4] : in_data[3:0];
   assign held       = cnt + {{(CW-1){1'b0}}, in_fire};

   // Accumulator with the current beat (if any) dropped into slot cnt.
   always_comb begin
      acc_ins = acc;
      if (in_fire) begin
         for (int i = 0; i < PACK_N; i++) begin
            if (cnt == CW'(i)) acc_ins[W-1-4*i -: 4] = nib;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         busy      <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            FILL: begin
               if (in_fire && last_slot) begin
                  // A completing beat wins over a same-cycle flush.
                  out_data  <= acc_ins;
                  out_count <= CW'(PACK_N);
                  out_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  busy      <= 1'b0;
               end else if (flush && held != '0) begin
                  if (slot_free) begin
                     out_data  <= acc_ins;
                     out_count <= held;
                     out_valid <= 1'b1;
                     acc       <= '0;
                     cnt       <= '0;
                     busy      <= 1'b0;
                  end else begin
                     acc   <= acc_ins;
                     cnt   <= held;
                     state <= FLUSH_WAIT;
                     busy  <= 1'b1;
                  end
               end else begin
                  acc  <= acc_ins;
                  cnt  <= held;
                  busy <= (held != '0);
               end
            end
            FLUSH_WAIT: begin
               if (slot_free) begin
                  out_data  <= acc;
                  out_count <= cnt;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  busy      <= 1'b0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - scoreboard bench for nibble_packer with a nibble-list reference model
module tb_nibble_packer;
   localparam int P  = 2;
   localparam int W  = 4 * P;
   localparam int CW = $clog2(P + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_data = '0;
   logic          nib_sel = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          busy;

   int errors = 0;
   int checks = 0;

   logic [3:0]   nq[$];
   logic [W-1:0] exp_d[$];
   int           exp_c[$];
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_d;

   nibble_packer #(.PACK_N(P)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .nib_sel(nib_sel), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void emit_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < nq.size(); i++) w = w | (W'(nq[i]) << (4 * (P - 1 - i)));
      exp_d.push_back(w);
      exp_c.push_back(nq.size());
      nq.delete();
   endfunction

   // Monitor first (words already formed), then reference model for this cycle's inputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         nq.delete();
         exp_d.delete();
         exp_c.delete();
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            checks++;
            if (!out_valid || out_data !== prev_d) begin
               errors++;
               $display("FAIL hold_stable: got valid=%0b data=0x%0h expected 0x%0h", out_valid, out_data, prev_d);
            end
         end
         hold_prev <= out_valid && !out_ready;
         prev_d    <= out_data;
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
               check("word_data", 32'(out_data), 32'(exp_d.pop_front()));
               check("word_count", 32'(out_count), 32'(exp_c.pop_front()));
            end
         end
         if (in_valid && in_ready) begin
            nq.push_back(nib_sel ? in_data[7:4] : in_data[3:0]);
            if (nq.size() == P) emit_word();
         end
         if (flush && nq.size() > 0) emit_word();
      end
   end

   task automatic send(input logic [7:0] d, input logic s);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      nib_sel  = s;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      send(8'h0E, 1'b0);
      send(8'h7F, 1'b0);
      check("pair1_valid", 32'(out_valid), 32'd1);
      check("pair1_data", 32'(out_data), 32'hEF);
      check("pair1_count", 32'(out_count), 32'd2);
      send(8'hF5, 1'b1);
      send(8'h08, 1'b0);
      check("pair2_data", 32'(out_data), 32'hF8);
      send(8'h0E, 1'b1);
      send(8'hAB, 1'b1);
      check("pair3_data", 32'(out_data), 32'h0A);

      @(posedge clk);
      #1 out_ready = 1'b0;
      send(8'h0E, 1'b0);
      send(8'h7F, 1'b0);
      check("blk_data", 32'(out_data), 32'hEF);
      send(8'h12, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h34;
      nib_sel  = 1'b0;
      @(negedge clk);
      check("blk_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("blk_hold", 32'(out_data), 32'hEF);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("blk_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_data", 32'(out_data), 32'h24);

      @(posedge clk);
      #1;
      send(8'h0E, 1'b0);
      pulse_flush();
      check("flush_data", 32'(out_data), 32'hE0);
      check("flush_count", 32'(out_count), 32'd1);
      pulse_flush();
      check("flush_empty_valid", 32'(out_valid), 32'd0);
      check("flush_empty_busy", 32'(busy), 32'd0);

      out_ready = 1'b0;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      pulse_flush();
      check("fw_in_ready", 32'(in_ready), 32'd0);
      check("fw_busy", 32'(busy), 32'd1);
      pulse_flush();
      check("fw_busy2", 32'(busy), 32'd1);
      check("fw_held", 32'(out_data), 32'h12);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("fw_data", 32'(out_data), 32'h30);
      check("fw_count", 32'(out_count), 32'd1);
      check("fw_busy_clear", 32'(busy), 32'd0);
      check("fw_in_ready_back", 32'(in_ready), 32'd1);

      @(posedge clk);
      #1;
      send(8'h05, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      check("post_rst_data", 32'(out_data), 32'h12);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         nib_sel   = 1'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      for (int c = 0; c < 20 && (exp_d.size() != 0 || out_valid); c++) @(posedge clk);
      #1;
      check("drain_queue_empty", 32'(exp_d.size()), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
